rasterizer_triangle_setup: RTL and testbench

//  Consumes vertices from the vertex fetch stage (one 96-bit {Z,Y,X} word per valid pulse), groups every

---
 rtl/rasterizer_pkg.sv | 31 +++
 rtl/rasterizer_edge_area.sv | 24 ++
 rtl/rasterizer_triangle_setup.sv | 168 ++++++++++++++++
 tb/tb_rasterizer_triangle_setup.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rasterizer_pkg.sv
// Shared types and defaults for the rasterizer triangle setup stage.
// Optional feature: CULL_BACKFACE_EN selects back-face culling in setup.
package rasterizer_pkg;

  localparam int DEF_COORD_W  = 16;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  typedef struct packed {
    logic [31:0] z;
    logic [31:0] y;
    logic [31:0] x;
  } vertex_t;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] ymax;
    logic [DEF_COORD_W-1:0] xmax;
    logic [DEF_COORD_W-1:0] ymin;
    logic [DEF_COORD_W-1:0] xmin;
  } bbox_t;

  typedef enum logic [2:0] {
    COLLECT0,
    COLLECT1,
    COLLECT2,
    DIFF,
    AREA,
    EMIT
  } setup_state_t;

endpackage

// File: rtl/rasterizer_edge_area.sv
// Signed doubled triangle area from the two edge vectors.
// Operands are widened first so the products never overflow.
module rasterizer_edge_area
  import rasterizer_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic signed [COORD_W:0]     dx1,
  input  logic signed [COORD_W:0]     dy1,
  input  logic signed [COORD_W:0]     dx2,
  input  logic signed [COORD_W:0]     dy2,
  output logic signed [2*COORD_W+2:0] area
);

  localparam int AW = 2*COORD_W+3;

  logic signed [AW-1:0] p1;
  logic signed [AW-1:0] p2;

  assign p1   = AW'(dx1) * AW'(dy2);
  assign p2   = AW'(dx2) * AW'(dy1);
  assign area = p1 - p2;

endmodule

// File: rtl/rasterizer_triangle_setup.sv
// Triangle setup: groups vertices, computes area/bbox, culls, emits.
// Define CULL_BACKFACE_EN to drop negative-area triangles.
module rasterizer_triangle_setup
  import rasterizer_pkg::*;
#(
  parameter int COORD_W  = DEF_COORD_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   vtx_valid,
  input  logic [95:0]            vtx_in,
  output logic                   vtx_ready,
  output logic                   tri_valid,
  input  logic                   tri_ready,
  output logic [287:0]           tri_vtx,
  output logic [2*COORD_W+2:0]   tri_area,
  output logic [4*COORD_W-1:0]   tri_bbox,
  output logic [15:0]            drop_count,
  output logic                   overflow
);

  localparam int DW = COORD_W+1;
  localparam int AW = 2*COORD_W+3;

  typedef logic signed [COORD_W-1:0] crd_t;

  setup_state_t state, state_nx;
  vertex_t v0, v1, v2;
  crd_t x0, y0, x1, y1, x2, y2;
  crd_t xmin, xmax, ymin, ymax;
  logic signed [DW-1:0] dx1, dy1, dx2, dy2;
  logic signed [AW-1:0] area, area_q;
  logic [4*COORD_W-1:0] bbox_q;
  logic drop, flip;

  assign x0 = v0.x[COORD_W-1:0];
  assign y0 = v0.y[COORD_W-1:0];
  assign x1 = v1.x[COORD_W-1:0];
  assign y1 = v1.y[COORD_W-1:0];
  assign x2 = v2.x[COORD_W-1:0];
  assign y2 = v2.y[COORD_W-1:0];

  function automatic crd_t min3(crd_t a, crd_t b, crd_t c);
    crd_t m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic crd_t max3(crd_t a, crd_t b, crd_t c);
    crd_t m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic logic [COORD_W-1:0] lo_clamp(crd_t v);
    return v[COORD_W-1] ? '0 : v;
  endfunction

  function automatic logic [COORD_W-1:0] hi_clamp(crd_t v, int lim);
    return (32'(v) > lim - 1) ? COORD_W'(lim - 1) : v;
  endfunction

  rasterizer_edge_area #(.COORD_W(COORD_W)) u_edge (
    .dx1  (dx1),
    .dy1  (dy1),
    .dx2  (dx2),
    .dy2  (dy2),
    .area (area)
  );

  always_comb begin
    drop = 1'b0;
    flip = 1'b0;
    if (area == '0) drop = 1'b1;
    if (xmax[COORD_W-1] || ymax[COORD_W-1]) drop = 1'b1;
    if (32'(xmin) >= SCREEN_W) drop = 1'b1;
    if (32'(ymin) >= SCREEN_H) drop = 1'b1;
    if (area[AW-1]) begin
`ifdef CULL_BACKFACE_EN
      drop = 1'b1;
`else
      flip = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= COLLECT0;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      COLLECT0: if (vtx_valid) state_nx = COLLECT1;
      COLLECT1: if (vtx_valid) state_nx = COLLECT2;
      COLLECT2: if (vtx_valid) state_nx = DIFF;
      DIFF:     state_nx = AREA;
      AREA:     state_nx = drop ? COLLECT0 : EMIT;
      EMIT:     if (tri_ready) state_nx = COLLECT0;
      default:  state_nx = COLLECT0;
    endcase
  end

  assign vtx_ready = state inside {COLLECT0, COLLECT1, COLLECT2};
  assign tri_valid = (state == EMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v0         <= '0;
      v1         <= '0;
      v2         <= '0;
      dx1        <= '0;
      dy1        <= '0;
      dx2        <= '0;
      dy2        <= '0;
      xmin       <= '0;
      xmax       <= '0;
      ymin       <= '0;
      ymax       <= '0;
      area_q     <= '0;
      bbox_q     <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (vtx_valid && !vtx_ready) overflow <= 1'b1;
      case (state)
        COLLECT0: if (vtx_valid) v0 <= vtx_in;
        COLLECT1: if (vtx_valid) v1 <= vtx_in;
        COLLECT2: if (vtx_valid) v2 <= vtx_in;
        DIFF: begin
          dx1  <= DW'(x1) - DW'(x0);
          dy1  <= DW'(y1) - DW'(y0);
          dx2  <= DW'(x2) - DW'(x0);
          dy2  <= DW'(y2) - DW'(y0);
          xmin <= min3(x0, x1, x2);
          xmax <= max3(x0, x1, x2);
          ymin <= min3(y0, y1, y2);
          ymax <= max3(y0, y1, y2);
        end
        AREA: begin
          area_q <= flip ? -area : area;
          bbox_q <= {hi_clamp(ymax, SCREEN_H), hi_clamp(xmax, SCREEN_W),
                     lo_clamp(ymin), lo_clamp(xmin)};
          // Swapping v1/v2 restores CCW winding for back faces
          if (flip) begin
            v1 <= v2;
            v2 <= v1;
          end
          if (drop && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign tri_vtx  = {v2, v1, v0};
  assign tri_area = area_q;
  assign tri_bbox = bbox_q;

endmodule

// File: tb/tb_rasterizer_triangle_setup.sv
// Randomized and directed bench for rasterizer_triangle_setup.
// Honours CULL_BACKFACE_EN when the build defines it.
module tb_rasterizer_triangle_setup;
  import rasterizer_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         vtx_valid = 1'b0;
  logic [95:0]  vtx_in = '0;
  logic         vtx_ready;
  logic         tri_valid;
  logic         tri_ready = 1'b0;
  logic [287:0] tri_vtx;
  logic [34:0]  tri_area;
  logic [63:0]  tri_bbox;
  logic [15:0]  drop_count;
  logic         overflow;

  int   checks = 0;
  int   errors = 0;
  int   exp_drop = 0;
  logic exp_ovf = 1'b0;

  rasterizer_triangle_setup dut (
    .clock      (clock),
    .reset      (reset),
    .vtx_valid  (vtx_valid),
    .vtx_in     (vtx_in),
    .vtx_ready  (vtx_ready),
    .tri_valid  (tri_valid),
    .tri_ready  (tri_ready),
    .tri_vtx    (tri_vtx),
    .tri_area   (tri_area),
    .tri_bbox   (tri_bbox),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [287:0] obs,
                       input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // X/Y upper halves and Z are random: only the low 16 bits are coordinates
  function automatic logic [95:0] mkv(input int x, input int y);
    logic [15:0] hx, hy;
    logic [31:0] z;
    hx = 16'($urandom);
    hy = 16'($urandom);
    z  = $urandom;
    return {z, hy, x[15:0], hx, y[15:0]} == 96'h0 ? '0 :
           {z, hy, y[15:0], hx, x[15:0]};
  endfunction

  task automatic send(input logic [95:0] v);
    vtx_in    = v;
    vtx_valid = 1'b1;
    @(negedge clock);
    vtx_valid = 1'b0;
  endtask

  task automatic run_tri(input logic [95:0] a, input logic [95:0] b,
                         input logic [95:0] c, input int hold,
                         input bit inject);
    logic [95:0] w[3];
    int x[3], y[3];
    longint ar;
    int xmn, xmx, ymn, ymx;
    bit drop, flip;
    logic [95:0] ev1, ev2;
    logic [34:0] ea;
    bbox_t eb;
    w[0] = a;
    w[1] = b;
    w[2] = c;
    for (int i = 0; i < 3; i++) begin
      x[i] = int'($signed(w[i][15:0]));
      y[i] = int'($signed(w[i][47:32]));
    end
    ar = longint'(x[1] - x[0]) * longint'(y[2] - y[0])
       - longint'(x[2] - x[0]) * longint'(y[1] - y[0]);
    xmn = x[0]; xmx = x[0]; ymn = y[0]; ymx = y[0];
    for (int i = 1; i < 3; i++) begin
      if (x[i] < xmn) xmn = x[i];
      if (x[i] > xmx) xmx = x[i];
      if (y[i] < ymn) ymn = y[i];
      if (y[i] > ymx) ymx = y[i];
    end
    drop = (ar == 0) || (xmx < 0) || (ymx < 0) || (xmn >= 640) || (ymn >= 480);
    flip = 1'b0;
    if (ar < 0) begin
`ifdef CULL_BACKFACE_EN
      drop = 1'b1;
`else
      flip = 1'b1;
`endif
    end
    tri_ready = (hold == 0);
    send(a);
    send(b);
    send(c);
    @(negedge clock);
    @(negedge clock);
    if (drop) begin
      if (exp_drop < 65535) exp_drop++;
      check("drop_valid", tri_valid, 0);
      check("drop_count", drop_count, exp_drop);
      check("drop_vtx_ready", vtx_ready, 1);
    end else begin
      ev1 = flip ? c : b;
      ev2 = flip ? b : c;
      ea = 35'(flip ? -ar : ar);
      eb.xmin = 16'(xmn < 0 ? 0 : xmn);
      eb.ymin = 16'(ymn < 0 ? 0 : ymn);
      eb.xmax = 16'(xmx > 639 ? 639 : xmx);
      eb.ymax = 16'(ymx > 479 ? 479 : ymx);
      check("latency_valid", tri_valid, 1);
      check("tri_vtx", tri_vtx, {ev2, ev1, a});
      check("tri_area", tri_area, ea);
      check("tri_bbox", tri_bbox, eb);
      check("emit_vtx_ready", vtx_ready, 0);
      if (hold > 0) begin
        for (int i = 0; i < hold; i++) begin
          if (inject && i == 0) begin
            send(mkv(1, 2));
            exp_ovf = 1'b1;
          end else begin
            @(negedge clock);
          end
        end
        check("hold_valid", tri_valid, 1);
        check("hold_vtx", tri_vtx, {ev2, ev1, a});
        check("hold_area", tri_area, ea);
        check("hold_bbox", tri_bbox, eb);
        check("hold_vtx_ready", vtx_ready, 0);
        tri_ready = 1'b1;
      end
      @(negedge clock);
      tri_ready = 1'b0;
      check("accepted", tri_valid, 0);
      check("ready_again", vtx_ready, 1);
    end
    check("overflow", overflow, exp_ovf);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_valid", tri_valid, 0);
    check("rst_vtx_ready", vtx_ready, 1);
    check("rst_drop", drop_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_vtx", tri_vtx, 0);
    check("rst_area", tri_area, 0);
    check("rst_bbox", tri_bbox, 0);
    reset = 1'b1;
    @(negedge clock);

    run_tri(mkv(0, 0), mkv(10, 0), mkv(0, 10), 0, 0);
    run_tri(mkv(0, 0), mkv(0, 10), mkv(10, 0), 0, 0);
    run_tri(mkv(5, 5), mkv(10, 10), mkv(15, 15), 0, 0);
    run_tri(mkv(0, 0), mkv(10, 0), mkv(0, 10), 2, 0);
    run_tri(mkv(-20, -20), mkv(700, -20), mkv(-20, 500), 0, 0);
    run_tri(mkv(700, 10), mkv(800, 10), mkv(700, 50), 0, 0);
    run_tri(mkv(0, 0), mkv(10, 0), mkv(0, 10), 20, 1);

    send(mkv(3, 4));
    send(mkv(30, 4));
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_valid", tri_valid, 0);
    check("mid_rst_vtx_ready", vtx_ready, 1);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_vtx", tri_vtx, 0);
    reset = 1'b1;
    exp_drop = 0;
    exp_ovf = 1'b0;
    @(negedge clock);
    run_tri(mkv(100, 100), mkv(200, 120), mkv(150, 300), 0, 0);

    for (int n = 0; n < 40; n++) begin
      run_tri(mkv(int'($urandom_range(900)) - 150, int'($urandom_range(800)) - 150),
              mkv(int'($urandom_range(900)) - 150, int'($urandom_range(800)) - 150),
              mkv(int'($urandom_range(900)) - 150, int'($urandom_range(800)) - 150),
              int'($urandom_range(3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
